// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha256_ctrl_pkg;

  localparam int unsigned ADDR_W                 = 16;
  localparam int unsigned JOBS_W                 = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RECOVER
  } ctrl_state_e;

  // (idx + offs) mod n for idx < n and offs <= n, without a divider.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned offs,
                                          input int unsigned n);
    int unsigned sum;
    sum = idx + offs;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the last grant.
module rr_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDX_W'(rr_next(32'(last_grant), k, N));
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sha256_job_arbiter.sv
// Shares one SHA-256 core between NUM_REQ requesters: round-robin grant,
// start/done sequencing, per-requester completion/timeout pulses and core watchdog.
module sha256_job_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_msg_addr,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_out_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_error,
  output logic                        core_start,
  output logic [ADDR_W-1:0]           core_message_addr,
  output logic [ADDR_W-1:0]           core_output_addr,
  output logic                        core_reset_n,
  input  logic                        core_done,
  output logic                        busy,
  output logic [JOBS_W-1:0]           jobs_completed
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              core_start_q, core_start_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic [NUM_REQ-1:0] req_error_q, req_error_d;
  logic [JOBS_W-1:0] jobs_q, jobs_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              rec_cnt_q, rec_cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [ADDR_W-1:0]  msg_addr_a [NUM_REQ];
  logic [ADDR_W-1:0]  out_addr_a [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign msg_addr_a[r] = req_msg_addr[r*ADDR_W +: ADDR_W];
    assign out_addr_a[r] = req_out_addr[r*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gidx_q       <= '0;
      msg_addr_q   <= '0;
      out_addr_q   <= '0;
      core_start_q <= 1'b0;
      req_done_q   <= '0;
      req_error_q  <= '0;
      jobs_q       <= '0;
      timer_q      <= '0;
      rec_cnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gidx_q       <= gidx_d;
      msg_addr_q   <= msg_addr_d;
      out_addr_q   <= out_addr_d;
      core_start_q <= core_start_d;
      req_done_q   <= req_done_d;
      req_error_q  <= req_error_d;
      jobs_q       <= jobs_d;
      timer_q      <= timer_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  always_comb begin
    logic [TMR_W-1:0] timer_inc;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gidx_d       = gidx_q;
    msg_addr_d   = msg_addr_q;
    out_addr_d   = out_addr_q;
    core_start_d = 1'b0;
    req_done_d   = '0;
    req_error_d  = '0;
    jobs_d       = jobs_q;
    timer_d      = timer_q;
    rec_cnt_d    = rec_cnt_q;
    req_ready_c  = '0;
    timer_inc    = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

    unique case (state_q)
      IDLE: begin
        // An idle core holds done high; a low done means it is not ready yet.
        req_ready_c = core_done ? grant : '0;
        if (|(req_valid & req_ready_c)) begin
          gidx_d       = grant_idx;
          last_grant_d = grant_idx;
          msg_addr_d   = msg_addr_a[grant_idx];
          out_addr_d   = out_addr_a[grant_idx];
          core_start_d = 1'b1;
          timer_d      = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_inc;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        timer_d = timer_inc;
        // Completion has priority over a watchdog expiry in the same cycle.
        if (state_q == WAIT_DONE && core_done) begin
          req_done_d[gidx_q] = 1'b1;
          jobs_d             = jobs_q + JOBS_W'(1);
          state_d            = IDLE;
        end else if (timer_q == TMR_LAST) begin
          req_error_d[gidx_q] = 1'b1;
          rec_cnt_d           = 1'b0;
          state_d             = RECOVER;
        end else if (state_q == WAIT_BUSY && !core_done) begin
          state_d = WAIT_DONE;
        end
      end
      RECOVER: begin
        if (rec_cnt_q) begin
          state_d = IDLE;
        end else begin
          rec_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready         = req_ready_c;
  assign req_done          = req_done_q;
  assign req_error         = req_error_q;
  assign core_start        = core_start_q;
  assign core_message_addr = msg_addr_q;
  assign core_output_addr  = out_addr_q;
  assign core_reset_n      = ~reset & (state_q != RECOVER);
  assign busy              = (state_q != IDLE);
  assign jobs_completed    = jobs_q;

endmodule
